// File: rtl/mux4_case_if.sv
// Bundle of the data, select and registered-output signals around mux4_case.
// Defining MUX4_CASE_PARITY_EN adds the out_par signal to both modports.
interface mux4_case_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [1:0]       select;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] sel_chg_cnt;
`ifdef MUX4_CASE_PARITY_EN
    logic             out_par;

    modport master (
        output in0, in1, in2, in3, select, in_valid,
        input  out, out_q, out_valid, sel_q, sel_chg_cnt, out_par
    );
    modport slave (
        input  in0, in1, in2, in3, select, in_valid,
        output out, out_q, out_valid, sel_q, sel_chg_cnt, out_par
    );
`else
    modport master (
        output in0, in1, in2, in3, select, in_valid,
        input  out, out_q, out_valid, sel_q, sel_chg_cnt
    );
    modport slave (
        input  in0, in1, in2, in3, select, in_valid,
        output out, out_q, out_valid, sel_q, sel_chg_cnt
    );
`endif
endinterface

// File: rtl/mux4_case.sv
// 4:1 case-decoded mux with a combinational output and a registered copy,
// valid flag and saturating select-change counter; MUX4_CASE_PARITY_EN adds out_par.
module mux4_case #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mux4_case_if.slave  bus
);
    logic [WIDTH-1:0] mux_val;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Default arm keeps the decode complete even for X/Z selects.
    always_comb begin
        mux_val = bus.in0;
        case (bus.select)
            2'd0:    mux_val = bus.in0;
            2'd1:    mux_val = bus.in1;
            2'd2:    mux_val = bus.in2;
            2'd3:    mux_val = bus.in3;
            default: mux_val = bus.in0;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            data_d = mux_val;
            sel_d  = bus.select;
            // Only a change relative to an immediately preceding accepted sample counts.
            if (valid_q && (bus.select != sel_q) && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.out         = mux_val;
    assign bus.out_q       = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.sel_q       = sel_q;
    assign bus.sel_chg_cnt = cnt_q;

`ifdef MUX4_CASE_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (bus.in_valid) begin
            par_d = ^mux_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.out_par = par_q;
`endif
endmodule

// File: tb/tb_mux4_case.sv
// Randomized self-checking bench for mux4_case: one instance with the default
// counter width and one with CNT_W=2, both checked against a behavioural model.
module tb_mux4_case;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mux4_case_if #(.WIDTH(2), .CNT_W(8)) a_if ();
    mux4_case_if #(.WIDTH(2), .CNT_W(2)) b_if ();

    mux4_case #(.WIDTH(2), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
    mux4_case #(.WIDTH(2), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic [1:0]  cur_in [4];
    logic [1:0]  cur_sel;
    logic        cur_vld;
    logic [1:0]  m_outq;
    logic        m_valid;
    logic [1:0]  m_sel;
    int unsigned m_cnt_a;
    int unsigned m_cnt_b;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] i2,
                         input logic [1:0] i3, input logic [1:0] sel, input logic vld);
        cur_in[0] = i0; cur_in[1] = i1; cur_in[2] = i2; cur_in[3] = i3;
        cur_sel = sel;
        cur_vld = vld;
        a_if.in0 = i0; a_if.in1 = i1; a_if.in2 = i2; a_if.in3 = i3;
        b_if.in0 = i0; b_if.in1 = i1; b_if.in2 = i2; b_if.in3 = i3;
        a_if.select = sel; b_if.select = sel;
        a_if.in_valid = vld; b_if.in_valid = vld;
    endtask

    task automatic model_reset();
        m_outq = 2'd0; m_valid = 1'b0; m_sel = 2'd0; m_cnt_a = 0; m_cnt_b = 0;
    endtask

    task automatic check_comb();
        check_eq("out_a", 32'(a_if.out), 32'(cur_in[cur_sel]));
        check_eq("out_b", 32'(b_if.out), 32'(cur_in[cur_sel]));
    endtask

    task automatic check_regs();
        check_eq("out_q", 32'(a_if.out_q), 32'(m_outq));
        check_eq("out_valid", 32'(a_if.out_valid), 32'(m_valid));
        check_eq("sel_q", 32'(a_if.sel_q), 32'(m_sel));
        check_eq("cnt_a", 32'(a_if.sel_chg_cnt), m_cnt_a);
        check_eq("cnt_b", 32'(b_if.sel_chg_cnt), m_cnt_b);
        check_eq("out_q_b", 32'(b_if.out_q), 32'(m_outq));
`ifdef MUX4_CASE_PARITY_EN
        check_eq("out_par", 32'(a_if.out_par), 32'(m_outq[0] ^ m_outq[1]));
`endif
    endtask

    // One clock edge: advance the model with the values applied, then check.
    task automatic clk_step();
        @(posedge clk);
        if (cur_vld) begin
            if (m_valid && (cur_sel != m_sel)) begin
                m_cnt_a = (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                m_cnt_b = (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
            end
            m_outq = cur_in[cur_sel];
            m_sel  = cur_sel;
        end
        m_valid = cur_vld;
        #1;
        check_regs();
    endtask

    task automatic cycle(input logic [1:0] sel, input logic vld);
        @(negedge clk);
        drive(2'b00, 2'b01, 2'b10, 2'b11, sel, vld);
        #1 check_comb();
        clk_step();
    endtask

    initial begin
        logic [1:0] seq [6];
        rst_n = 1'b0;
        drive(2'b00, 2'b01, 2'b10, 2'b11, 2'd0, 1'b0);
        model_reset();
        #3;
        check_regs();

        // Combinational sweep, registers held in reset.
        for (int s = 0; s < 4; s++) begin
            drive(2'b00, 2'b01, 2'b10, 2'b11, 2'(s), 1'b0);
            #5 check_comb();
        end
        for (int k = 0; k < 100; k++) begin
            drive(2'b00, 2'b01, 2'b10, 2'b11, 2'($urandom_range(0, 3)), 1'b0);
            #5 check_comb();
        end

        @(negedge clk) rst_n = 1'b1;

        // Build up out_q=11, cnt=5 (dut_b saturates at 3), then async reset mid-cycle.
        seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
        for (int k = 0; k < 6; k++) cycle(seq[k], 1'b1);
        check_eq("pre_rst_cnt", 32'(a_if.sel_chg_cnt), 32'd5);
        check_eq("pre_rst_outq", 32'(a_if.out_q), 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_regs();
        drive(2'b00, 2'b01, 2'b10, 2'b11, 2'd2, 1'b1);
        #1 check_comb();
        @(negedge clk) rst_n = 1'b1;

        // Capture select=2, then drop in_valid while select moves to 3.
        cycle(2'd2, 1'b1);
        check_eq("hold_outq1", 32'(a_if.out_q), 32'd2);
        cycle(2'd3, 1'b0);
        check_eq("hold_outq2", 32'(a_if.out_q), 32'd2);
        check_eq("hold_valid", 32'(a_if.out_valid), 32'd0);
        cycle(2'd3, 1'b0);

        // Saturation on the narrow counter.
        @(negedge clk) rst_n = 1'b0;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        seq = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
        for (int k = 0; k < 6; k++) cycle(seq[k], 1'b1);
        check_eq("sat_cnt_b", 32'(b_if.sel_chg_cnt), 32'd3);

`ifdef MUX4_CASE_PARITY_EN
        cycle(2'd3, 1'b1);
        check_eq("par_11", 32'(a_if.out_par), 32'd0);
        cycle(2'd1, 1'b1);
        check_eq("par_01", 32'(a_if.out_par), 32'd1);
`endif

        // Random data, selects and valid gaps.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            drive(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
            #1 check_comb();
            clk_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
